// File: rtl/tgrp_swap_sched.sv
// Thread-group swap scheduler: periodic and on-demand swap strobes for mt_cpu,
// with deferral while the CPU holds off and round-robin group tracking.
module tgrp_swap_sched #(
    parameter int NUM_TGRPS      = 2,
    parameter int CNT_WIDTH      = 8,
    parameter int DEFAULT_PERIOD = 25,
    parameter int SWAP_CNT_WIDTH = 16,
    localparam int TW = (NUM_TGRPS > 2) ? $clog2(NUM_TGRPS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic                      period_wr,
    input  logic [CNT_WIDTH-1:0]      period_in,
    input  logic                      swap_req,
    input  logic                      hold,
    output logic                      swap_tgrp,
    output logic [TW-1:0]             active_tgrp,
    output logic                      pending,
    output logic [SWAP_CNT_WIDTH-1:0] swap_count,
    output logic [SWAP_CNT_WIDTH-1:0] drop_count
);

    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]      period_q, period_d;
    logic                      swap_q, swap_d;
    logic [TW-1:0]             active_q, active_d;
    logic                      pending_q, pending_d;
    logic [SWAP_CNT_WIDTH-1:0] swaps_q, swaps_d;
    logic [SWAP_CNT_WIDTH-1:0] drops_q, drops_d;

    logic                      run, per_on, od_on;
    logic [CNT_WIDTH-1:0]      p_eff;
    logic                      term;
    logic                      per_evt, od_evt, issue;
    logic [1:0]                n_src, merged;
    logic [SWAP_CNT_WIDTH:0]   drop_sum;

    assign run    = en && (mode != 2'b11);
    assign per_on = en && ((mode == 2'b00) || (mode == 2'b10));
    assign od_on  = en && ((mode == 2'b01) || (mode == 2'b10));

    assign p_eff   = (period_q < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : period_q;
    assign term    = (cnt_q >= (p_eff - CNT_WIDTH'(1)));
    assign per_evt = per_on && !period_wr && term;
    assign od_evt  = od_on && swap_req && !swap_q;

    // A swap right after a strobe is deferred so the strobe never stretches.
    assign issue = (per_evt || od_evt || pending_q) && run && !hold && !swap_q;

    // Every event source beyond the first one folded into a swap is a drop.
    assign n_src  = {1'b0, per_evt} + {1'b0, od_evt} + {1'b0, pending_q};
    assign merged = (n_src != 2'd0) ? (n_src - 2'd1) : 2'd0;

    assign drop_sum = {1'b0, drops_q} + (SWAP_CNT_WIDTH + 1)'(merged);

    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        swap_d    = issue;
        active_d  = active_q;
        pending_d = pending_q;
        swaps_d   = swaps_q;
        drops_d   = drops_q;

        if (period_wr) begin
            period_d = period_in;
            cnt_d    = '0;
        end else if (per_on) begin
            cnt_d = term ? '0 : cnt_q + CNT_WIDTH'(1);
        end

        if (issue) begin
            pending_d = 1'b0;
            swaps_d   = swaps_q + SWAP_CNT_WIDTH'(1);
            if (active_q == TW'(NUM_TGRPS - 1))
                active_d = '0;
            else
                active_d = active_q + TW'(1);
        end else if (per_evt || od_evt) begin
            pending_d = 1'b1;
        end

        if (drop_sum[SWAP_CNT_WIDTH])
            drops_d = '1;
        else
            drops_d = drop_sum[SWAP_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            period_q  <= CNT_WIDTH'(DEFAULT_PERIOD);
            swap_q    <= 1'b0;
            active_q  <= '0;
            pending_q <= 1'b0;
            swaps_q   <= '0;
            drops_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            swap_q    <= swap_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            swaps_q   <= swaps_d;
            drops_q   <= drops_d;
        end
    end

    assign swap_tgrp   = swap_q;
    assign active_tgrp = active_q;
    assign pending     = pending_q;
    assign swap_count  = swaps_q;
    assign drop_count  = drops_q;

endmodule

// File: tb/tb_tgrp_swap_sched.sv
// Directed bench for tgrp_swap_sched: two instances, two and three thread groups.
module tb_tgrp_swap_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        period_wr;
    logic [7:0]  period_in;
    logic        swap_req;
    logic        hold;

    logic        swap_tgrp, pending;
    logic [0:0]  active_tgrp;
    logic [15:0] swap_count, drop_count;

    logic        swap_tgrp3, pending3;
    logic [1:0]  active_tgrp3;
    logic [15:0] swap_count3, drop_count3;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    tgrp_swap_sched dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .period_wr(period_wr), .period_in(period_in),
        .swap_req(swap_req), .hold(hold),
        .swap_tgrp(swap_tgrp), .active_tgrp(active_tgrp),
        .pending(pending), .swap_count(swap_count),
        .drop_count(drop_count)
    );

    tgrp_swap_sched #(.NUM_TGRPS(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .period_wr(period_wr), .period_in(period_in),
        .swap_req(swap_req), .hold(hold),
        .swap_tgrp(swap_tgrp3), .active_tgrp(active_tgrp3),
        .pending(pending3), .swap_count(swap_count3),
        .drop_count(drop_count3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge; the next edge is edge 1.
    task automatic apply_reset();
        rst       = 1'b0;
        en        = 1'b0;
        mode      = 2'b00;
        period_wr = 1'b0;
        period_in = 8'd0;
        swap_req  = 1'b0;
        hold      = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (swap_tgrp !== 1'b0) begin
            fails++;
            $display("FAIL reset_swap got %b expected 0", swap_tgrp);
        end
        checks++;
        if (active_tgrp !== 1'b0) begin
            fails++;
            $display("FAIL reset_active got %0d expected 0", active_tgrp);
        end
        checks++;
        if (pending !== 1'b0) begin
            fails++;
            $display("FAIL reset_pending got %b expected 0", pending);
        end
        checks++;
        if (swap_count !== 16'd0 || drop_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_counts got %0d/%0d expected 0/0",
                     swap_count, drop_count);
        end
    endtask

    task automatic test_periodic();
        logic exp;
        apply_reset();
        en = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            tick();
            exp = (e % 25 == 0);
            checks++;
            if (swap_tgrp !== exp) begin
                fails++;
                $display("FAIL periodic_strobe edge %0d got %b expected %b",
                         e, swap_tgrp, exp);
            end
            if (e % 25 == 0) begin
                checks++;
                if (active_tgrp !== 1'((e / 25) % 2)) begin
                    fails++;
                    $display("FAIL periodic_active edge %0d got %0d expected %0d",
                             e, active_tgrp, (e / 25) % 2);
                end
            end
        end
        checks++;
        if (swap_count !== 16'd8 || drop_count !== 16'd0) begin
            fails++;
            $display("FAIL periodic_counts got %0d/%0d expected 8/0",
                     swap_count, drop_count);
        end
        checks++;
        if (active_tgrp3 !== 2'd2) begin
            fails++;
            $display("FAIL periodic_active3 got %0d expected 2", active_tgrp3);
        end
    endtask

    task automatic test_reset_mid();
        logic exp;
        apply_reset();
        en = 1'b1;
        for (int e = 1; e <= 12; e++) tick();
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (swap_tgrp !== 1'b0 || swap_count !== 16'd0 || active_tgrp !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outputs got %b/%0d/%0d expected 0/0/0",
                     swap_tgrp, swap_count, active_tgrp);
        end
        tick();
        rst = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick();
            exp = (e == 25);
            checks++;
            if (swap_tgrp !== exp) begin
                fails++;
                $display("FAIL midreset_restart edge %0d got %b expected %b",
                         e, swap_tgrp, exp);
            end
        end
        hold = 1'b1;
        for (int e = 1; e <= 25; e++) tick();
        checks++;
        if (pending !== 1'b1 || swap_count !== 16'd1) begin
            fails++;
            $display("FAIL held_pending got %b/%0d expected 1/1",
                     pending, swap_count);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (pending !== 1'b0 || swap_count !== 16'd0 || active_tgrp !== 1'b0) begin
            fails++;
            $display("FAIL pendreset_outputs got %b/%0d/%0d expected 0/0/0",
                     pending, swap_count, active_tgrp);
        end
        hold = 1'b0;
        tick();
        rst = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick();
            exp = (e == 25);
            checks++;
            if (swap_tgrp !== exp) begin
                fails++;
                $display("FAIL pendreset_restart edge %0d got %b expected %b",
                         e, swap_tgrp, exp);
            end
        end
    endtask

    task automatic test_period_wr();
        logic exp;
        apply_reset();
        en = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            if (e == 10) begin
                period_wr = 1'b1;
                period_in = 8'd5;
            end
            if (e == 11) period_wr = 1'b0;
            if (e == 25) begin
                period_wr = 1'b1;
                period_in = 8'd0;
            end
            if (e == 26) period_wr = 1'b0;
            tick();
            exp = (e == 15) || (e == 20) || (e >= 27 && e % 2 == 1);
            checks++;
            if (swap_tgrp !== exp) begin
                fails++;
                $display("FAIL period_strobe edge %0d got %b expected %b",
                         e, swap_tgrp, exp);
            end
        end
    endtask

    task automatic test_hold();
        logic exp;
        apply_reset();
        en = 1'b1;
        for (int e = 1; e <= 61; e++) begin
            if (e == 20) hold = 1'b1;
            if (e == 61) hold = 1'b0;
            tick();
            exp = (e == 61);
            checks++;
            if (swap_tgrp !== exp) begin
                fails++;
                $display("FAIL hold_strobe edge %0d got %b expected %b",
                         e, swap_tgrp, exp);
            end
            exp = (e >= 25 && e <= 60);
            checks++;
            if (pending !== exp) begin
                fails++;
                $display("FAIL hold_pending edge %0d got %b expected %b",
                         e, pending, exp);
            end
            if (e == 49 || e == 50) begin
                checks++;
                if (drop_count !== 16'(e - 49)) begin
                    fails++;
                    $display("FAIL hold_drop edge %0d got %0d expected %0d",
                             e, drop_count, e - 49);
                end
            end
        end
        checks++;
        if (swap_count !== 16'd1 || active_tgrp !== 1'b1 || drop_count !== 16'd1) begin
            fails++;
            $display("FAIL hold_final got %0d/%0d/%0d expected 1/1/1",
                     swap_count, active_tgrp, drop_count);
        end
    endtask

    task automatic test_on_demand();
        logic       exp;
        logic [1:0] exp_a;
        apply_reset();
        en       = 1'b1;
        mode     = 2'b01;
        swap_req = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = (e % 2 == 1);
            checks++;
            if (swap_tgrp3 !== exp) begin
                fails++;
                $display("FAIL od_strobe edge %0d got %b expected %b",
                         e, swap_tgrp3, exp);
            end
            if (exp) begin
                exp_a = 2'(((e + 1) / 2) % 3);
                checks++;
                if (active_tgrp3 !== exp_a) begin
                    fails++;
                    $display("FAIL od_active edge %0d got %0d expected %0d",
                             e, active_tgrp3, exp_a);
                end
            end
        end
        swap_req = 1'b0;
        tick();
        checks++;
        if (swap_tgrp3 !== 1'b0 || swap_count3 !== 16'd5 || drop_count3 !== 16'd0) begin
            fails++;
            $display("FAIL od_final got %b/%0d/%0d expected 0/5/0",
                     swap_tgrp3, swap_count3, drop_count3);
        end
    endtask

    task automatic test_merge_and_disable();
        logic exp;
        apply_reset();
        en   = 1'b1;
        mode = 2'b10;
        for (int e = 1; e <= 30; e++) begin
            if (e == 25) swap_req = 1'b1;
            if (e == 26) swap_req = 1'b0;
            tick();
            exp = (e == 25);
            checks++;
            if (swap_tgrp !== exp) begin
                fails++;
                $display("FAIL merge_strobe edge %0d got %b expected %b",
                         e, swap_tgrp, exp);
            end
        end
        checks++;
        if (swap_count !== 16'd1 || drop_count !== 16'd1) begin
            fails++;
            $display("FAIL merge_counts got %0d/%0d expected 1/1",
                     swap_count, drop_count);
        end
        en       = 1'b0;
        swap_req = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            checks++;
            if (swap_tgrp !== 1'b0 || pending !== 1'b0) begin
                fails++;
                $display("FAIL disabled_quiet edge %0d got %b/%b expected 0/0",
                         e, swap_tgrp, pending);
            end
        end
        swap_req = 1'b0;
        en       = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp = (e == 20);
            checks++;
            if (swap_tgrp !== exp) begin
                fails++;
                $display("FAIL frozen_count edge %0d got %b expected %b",
                         e, swap_tgrp, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_reset_mid();
        test_period_wr();
        test_hold();
        test_on_demand();
        test_merge_and_disable();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
